dir_button_conditioner: RTL and testbench
=========================================

// Module: dir_button_conditioner
// PURPOSE
//  Conditions the four raw board direction buttons before they reach the maze/block controller's up/down/left/right inputs.
//  Per button: 2-flop synchronizer, counter debounce, press state machine.
//  Outputs per button: debounced level, single-cycle press pulse, and opposing-pair-masked move levels.
//  Runs on the fast board clock, upstream of the game-logic clock domain.
// PARAMETERS
//  DEBOUNCE_CYCLES  100000  consecutive stable cycles needed to accept a level change (>=2)
//  REPEAT_DELAY     50000000  cycles held before the first auto-repeat pulse (BTN_AUTOREPEAT_EN only)
//  REPEAT_PERIOD    10000000  cycles between subsequent auto-repeat pulses (BTN_AUTOREPEAT_EN only)
// PORTS
//  clk        in   1  board clock
//  rst        in   1  reset, asynchronous, active-high
//  btn_raw    in   4  raw buttons {up,down,left,right}, asynchronous, active-high
//  btn_level  out  4  debounced level, same bit order
//  btn_pulse  out  4  1-cycle strobe per accepted press (plus repeats if enabled)
//  move_up    out  1  btn_level[3] & ~btn_level[2]
//  move_down  out  1  btn_level[2] & ~btn_level[3]
//  move_left  out  1  btn_level[1] & ~btn_level[0]
//  move_right out  1  btn_level[0] & ~btn_level[1]
//  any_held   out  1  |btn_level
// BEHAVIOUR
//  Reset: all outputs 0; sync flops 0; counters 0; every FSM in RELEASED. Takes effect immediately, even mid-debounce.
//  Sync: sync1 <= btn_raw; sync2 <= sync1. Only sync2 is used downstream.
//  Per-button FSM:
//   RELEASED
//    - sync2=1 -> PRESS_WAIT, cnt<=1.
//   PRESS_WAIT
//    - sync2=0 -> RELEASED, cnt<=0 (glitch rejected, no pulse).
//    - sync2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; level<=1; pulse<=1 for exactly one cycle.
//    - otherwise cnt++.
//   PRESSED
//    - sync2=0 -> RELEASE_WAIT, cnt<=1.
//   RELEASE_WAIT
//    - sync2=1 -> PRESSED, cnt<=0; level stays 1, no new pulse.
//    - sync2=0 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED; level<=0.
//    - otherwise cnt++.
//  Latency: raw held stable from edge E0 (first edge sampling it)
//   - sync2 high after E1.
//   - level and pulse registered at E(DEBOUNCE_CYCLES+1), i.e. DEBOUNCE_CYCLES+1 edges after E0.
//   - Release latency is identical.
//  Counter width: $clog2(max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_PERIOD))+1; the counter never wraps.
//  Buttons are independent; simultaneous presses on several bits produce simultaneous pulses.
//  Opposing pair held (up+down or left+right): both move outputs of that pair are 0; btn_level still shows both.
//  move_* and any_held are combinational from registered btn_level (no extra latency).
//  btn_pulse is registered and high for one clk only; it never asserts in RELEASE_WAIT or RELEASED.
// CONFIGURATION
//  BTN_AUTOREPEAT_EN defined:
//   - A per-button repeat counter runs while in PRESSED; it starts at 0 on entry.
//   - Extra 1-cycle pulse when it reaches REPEAT_DELAY-1, then every REPEAT_PERIOD cycles after that.
//   - Entering RELEASE_WAIT freezes the counter.
//   - Returning to PRESSED from RELEASE_WAIT resumes without restarting.
//   - Entering RELEASED clears it.
//  BTN_AUTOREPEAT_EN undefined:
//   - Repeat logic absent; exactly one pulse per accepted press.
//   - REPEAT_* parameters are ignored.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1. Assert rst mid-run with btn_raw=4'b1111 -> all outputs 0 immediately.
//     Deassert and hold -> btn_level=4'b1111 and one 4-bit pulse 5 edges later.
//  2. btn_raw[3] high 3 cycles then low -> btn_level and btn_pulse stay 0 (glitch rejected).
//  3. btn_raw[0] high and held -> btn_pulse[0] exactly one cycle, at edge 5.
//     Release -> btn_level[0] falls 5 edges after release; no pulse on release.
//  4. Hold up, then add down -> move_up=1 then 0; move_down=0; btn_level=4'b1100.
//  5. While PRESSED, bounce raw low for 2 cycles -> btn_level stays 1; no second pulse.
//  6. With BTN_AUTOREPEAT_EN, hold right 30 cycles past acceptance -> pulses at acceptance, +10, +13, +16, +19, ...
//     Without the macro -> a single pulse only.

Source files
------------

// File: rtl/dir_button_conditioner.sv
// dir_button_conditioner
//   Conditions the four raw board direction buttons {up,down,left,right}
//   for the maze/block controller. Each button passes through a 2-flop
//   synchronizer, a counter debounce and a press state machine.
//
//   Optional feature macro: BTN_AUTOREPEAT_EN
//     When defined, a held button emits extra one-cycle pulses after
//     REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
//
// Ports
//   clk        board clock
//   rst        asynchronous, active-high reset
//   btn_raw    raw buttons {up,down,left,right}, asynchronous
//   btn_level  debounced level, same bit order
//   btn_pulse  one-cycle strobe per accepted press (plus repeats if enabled)
//   move_up    up held and down not held
//   move_down  down held and up not held
//   move_left  left held and right not held
//   move_right right held and left not held
//   any_held   any debounced button held
module dir_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       any_held
);

  localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_e;

  logic [3:0] sync1;
  logic [3:0] sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_btn
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             s;
    logic             rpt_pulse;

    assign s = sync2[b];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        RELEASED: begin
          cnt_d = '0;
          if (s) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
        end
      endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    // Repeat counter advances only on cycles that stay in PRESSED, so a
    // bounce through RELEASE_WAIT freezes it. rpt_mode distinguishes the
    // initial delay from the periodic phase; the counter restarts at 0
    // after each fire so it never exceeds the larger of the two limits.
    logic [CNT_W-1:0] rpt_q, rpt_d;
    logic             rpt_mode_q, rpt_mode_d;
    logic             rpt_hit;

    assign rpt_hit = rpt_mode_q ? (rpt_q == RP_LAST) : (rpt_q == RD_LAST);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt_q      <= '0;
        rpt_mode_q <= 1'b0;
      end else begin
        rpt_q      <= rpt_d;
        rpt_mode_q <= rpt_mode_d;
      end
    end

    always_comb begin
      rpt_d      = rpt_q;
      rpt_mode_d = rpt_mode_q;
      rpt_pulse  = 1'b0;
      if (state_d == RELEASED) begin
        rpt_d      = '0;
        rpt_mode_d = 1'b0;
      end else if (state_q == PRESSED && s) begin
        if (rpt_hit) begin
          rpt_pulse  = 1'b1;
          rpt_d      = '0;
          rpt_mode_d = 1'b1;
        end else begin
          rpt_d = rpt_q + CNT_W'(1);
        end
      end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    always_comb begin
      level_d = level_q;
      pulse_d = 1'b0;
      case (state_q)
        PRESS_WAIT: begin
          if (s && cnt_q == DB_LAST) begin
            level_d = 1'b1;
            pulse_d = 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (!s && cnt_q == DB_LAST) begin
            level_d = 1'b0;
          end
        end
        PRESSED: pulse_d = rpt_pulse;
        default: ;
      endcase
    end

    assign btn_level[b] = level_q;
    assign btn_pulse[b] = pulse_q;
  end

  assign move_up    = btn_level[3] & ~btn_level[2];
  assign move_down  = btn_level[2] & ~btn_level[3];
  assign move_left  = btn_level[1] & ~btn_level[0];
  assign move_right = btn_level[0] & ~btn_level[1];
  assign any_held   = |btn_level;

endmodule

// File: tb/tb_dir_button_conditioner.sv
// Self-checking bench for dir_button_conditioner with small timing
// parameters. A behavioural model tracks, per button, how many consecutive
// synchronized samples disagree with the accepted level; the level flips
// once that run reaches DEBOUNCE_CYCLES.
module tb_dir_button_conditioner;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic       move_up, move_down, move_left, move_right, any_held;

  int checks = 0;
  int errors = 0;

  dir_button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .move_up   (move_up),
    .move_down (move_down),
    .move_left (move_left),
    .move_right(move_right),
    .any_held  (any_held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_r1 = 4'b0000;
  logic [3:0] m_r2 = 4'b0000;
  logic [3:0] m_seen = 4'b0000;
  logic [3:0] m_level = 4'b0000;
  logic [3:0] m_pulse = 4'b0000;
  int run[4] = '{0, 0, 0, 0};
  int held[4] = '{0, 0, 0, 0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r1 = '0; m_r2 = '0; m_level = '0; m_pulse = '0;
      for (int b = 0; b < 4; b++) begin
        run[b] = 0; held[b] = 0;
      end
    end else begin
      m_seen = m_r2;
      m_r2 = m_r1;
      m_r1 = btn_raw;
      m_pulse = '0;
      for (int b = 0; b < 4; b++) begin
        if (m_seen[b] != m_level[b]) begin
          run[b]++;
          if (run[b] == int'(DB)) begin
            m_level[b] = ~m_level[b];
            run[b] = 0;
            held[b] = 0;
            if (m_level[b]) m_pulse[b] = 1'b1;
          end
        end else begin
          if (m_level[b] && run[b] == 0) begin
            held[b]++;
`ifdef BTN_AUTOREPEAT_EN
            if (held[b] == int'(RD) || (held[b] > int'(RD) && (held[b] - int'(RD)) % int'(RP) == 0))
              m_pulse[b] = 1'b1;
`endif
          end
          run[b] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_level", int'(btn_level), int'(m_level));
    chk("cmp_pulse", int'(btn_pulse), int'(m_pulse));
    chk("cmp_moves", int'({move_up, move_down, move_left, move_right}),
        int'({m_level[3] & ~m_level[2], m_level[2] & ~m_level[3],
              m_level[1] & ~m_level[0], m_level[0] & ~m_level[1]}));
    chk("cmp_any", int'(any_held), int'(|m_level));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int pc, pe, np, fall, first;
    int offs[$];
    int exp_offs[$];

    #1;
    chk("reset_level", int'(btn_level), 0);
    chk("reset_pulse", int'(btn_pulse), 0);
    chk("reset_any", int'(any_held), 0);
    @(negedge clk);
    rst = 1'b0;

    // glitch of 3 samples is rejected
    pc = 0;
    btn_raw = 4'b1000;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (btn_pulse != 0) pc++; end
    btn_raw = 4'b0000;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (btn_pulse != 0) pc++; end
    chk("glitch_pulses", pc, 0);
    chk("glitch_level", int'(btn_level), 0);

    // press right: single pulse at edge 5
    btn_raw = 4'b0001;
    np = 0; pe = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (btn_pulse[0]) begin np++; pe = i; end
    end
    chk("press_pulse_edge", pe, 5);
    chk("press_pulse_count", np, 1);
    chk("press_level", int'(btn_level), 1);
    btn_raw = 4'b0000;
    np = 0; fall = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!btn_level[0] && fall < 0) fall = i;
      if (btn_pulse[0]) np++;
    end
    chk("release_fall_edge", fall, 5);
    chk("release_pulses", np, 0);

    // opposing pair up+down
    btn_raw = 4'b1000;
    step(6);
    chk("up_alone_move_up", int'(move_up), 1);
    chk("up_alone_level", int'(btn_level), 8);
    btn_raw = 4'b1100;
    step(6);
    chk("updown_level", int'(btn_level), 12);
    chk("updown_move_up", int'(move_up), 0);
    chk("updown_move_down", int'(move_down), 0);
    chk("updown_any", int'(any_held), 1);
    btn_raw = 4'b0000;
    step(8);
    chk("updown_released", int'(btn_level), 0);

    // bounce while pressed: level stays, no second pulse
    btn_raw = 4'b0010;
    step(6);
    chk("bounce_pre_level", int'(btn_level), 2);
    chk("bounce_move_left", int'(move_left), 1);
    pc = 0;
    btn_raw = 4'b0000;
    for (int i = 0; i < 2; i++) begin @(negedge clk); if (btn_pulse != 0) pc++; end
    btn_raw = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (btn_pulse != 0) pc++;
      chk("bounce_level_held", int'(btn_level), 2);
    end
    chk("bounce_pulses", pc, 0);
    btn_raw = 4'b0000;
    step(8);

    // long hold on right
`ifdef BTN_AUTOREPEAT_EN
    exp_offs = '{0, 10, 13, 16, 19, 22, 25, 28};
`else
    exp_offs = '{0};
`endif
    btn_raw = 4'b0001;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (btn_pulse[0]) offs.push_back(i - 5);
    end
    chk("hold_pulse_count", offs.size(), exp_offs.size());
    for (int j = 0; j < exp_offs.size() && j < offs.size(); j++)
      chk("hold_pulse_offset", offs[j], exp_offs[j]);
    btn_raw = 4'b0000;
    step(8);

    // asynchronous reset mid-run with all buttons held
    btn_raw = 4'b1111;
    step(8);
    chk("all_level", int'(btn_level), 15);
    chk("all_moves", int'({move_up, move_down, move_left, move_right}), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_level", int'(btn_level), 0);
    chk("midrst_pulse", int'(btn_pulse), 0);
    chk("midrst_any", int'(any_held), 0);
    @(negedge clk);
    rst = 1'b0;
    first = -1; np = 0; pe = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (btn_level == 4'b1111 && first < 0) first = i;
      if (btn_pulse != 0) begin np++; pe = int'(btn_pulse); end
    end
    chk("postrst_level_edge", first, 5);
    chk("postrst_pulse_count", np, 1);
    chk("postrst_pulse_value", pe, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
